// File: rtl/sigma_delta_adc_if.sv
// sigma_delta_adc_if
//   Groups the converter's sample-path signals so the ADC and its driver/consumer
//   connect through one port.
//   Signals:
//     enable       decimator count enable (driver -> ADC)
//     comp_in      raw asynchronous comparator output (driver -> ADC)
//     fb_out       registered feedback bit to the RC integrator (ADC -> driver)
//     sample       last completed PCM sample, excess-128 (ADC -> consumer)
//     sample_valid one-cycle strobe, sample updated this cycle (ADC -> consumer)
//     ear          hysteresis-decoded EAR level (ADC -> consumer)
//     ear_state    EAR FSM state, 0 = LOW, 1 = HIGH (debug observation)
//   Handshake: sample_valid is a push-only strobe with no ready/backpressure.
//   It is high for exactly one clock when sample has just been rewritten; a
//   consumer that needs the value must capture it on that clock.
interface sigma_delta_adc_if;
  logic       enable;
  logic       comp_in;
  logic       fb_out;
  logic [7:0] sample;
  logic       sample_valid;
  logic       ear;
  logic       ear_state;

  modport master (
    output enable, comp_in,
    input  fb_out, sample, sample_valid, ear, ear_state
  );

  modport slave (
    input  enable, comp_in,
    output fb_out, sample, sample_valid, ear, ear_state
  );
endinterface

// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc
//   First-order delta-sigma ADC back end. The comparator output is synchronized,
//   fed back to the external RC integrator, and counted over a window of
//   2^DECIM_LOG2 enabled clocks. Each window produces an 8-bit excess-128 PCM
//   sample and updates a hysteresis-decoded EAR bit for the tape-load path.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    sigma_delta_adc_if.slave (enable, comp_in in; fb_out, sample,
//            sample_valid, ear, ear_state out)
//   Parameters:
//     DECIM_LOG2  window length exponent, 4..12
//     HYST        EAR hysteresis half-width around 128, 0..127
module sigma_delta_adc #(
  parameter int         DECIM_LOG2 = 8,
  parameter logic [7:0] HYST       = 8'd16
) (
  input logic              clk,
  input logic              reset,
  sigma_delta_adc_if.slave bus
);

  typedef enum logic {
    EAR_LOW  = 1'b0,
    EAR_HIGH = 1'b1
  } ear_state_t;

  logic                  s1;
  logic                  s2;
  logic                  fb;
  logic [DECIM_LOG2-1:0] win_cnt;
  logic [DECIM_LOG2:0]   ones;
  logic [7:0]            sample_r;
  logic                  valid_r;
  ear_state_t            state;
  ear_state_t            state_next;

  logic                  win_last;
  logic [DECIM_LOG2:0]   total;
  logic [DECIM_LOG2-1:0] sat;
  logic [7:0]            scaled;

  assign win_last = bus.enable && (win_cnt == '1);

  // Count including the current bit; a full window of ones (2^N) is the only
  // value that needs saturating to fit the N-bit range.
  assign total = ones + {{DECIM_LOG2{1'b0}}, s2};
  assign sat   = total[DECIM_LOG2] ? '1 : total[DECIM_LOG2-1:0];

  // Normalize the N-bit count to 8 bits: keep the top 8 bits, or pad low zeros.
  generate
    if (DECIM_LOG2 >= 8) begin : g_shr
      assign scaled = sat[DECIM_LOG2-1 -: 8];
    end else begin : g_shl
      assign scaled = {sat, {(8 - DECIM_LOG2){1'b0}}};
    end
  endgenerate

  // Synchronizer, feedback and decimator. The feedback path ignores enable so
  // the analog loop never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      fb       <= 1'b0;
      win_cnt  <= '0;
      ones     <= '0;
      sample_r <= 8'h80;
      valid_r  <= 1'b0;
    end else begin
      s1 <= bus.comp_in;
      s2 <= s1;
      fb <= s2;
      if (bus.enable) begin
        if (win_last) begin
          ones     <= '0;
          win_cnt  <= '0;
          sample_r <= scaled;
          valid_r  <= 1'b1;
        end else begin
          ones    <= total;
          win_cnt <= win_cnt + 1'b1;
          valid_r <= 1'b0;
        end
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  // EAR FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EAR_LOW;
    end else begin
      state <= state_next;
    end
  end

  // EAR FSM next state: judged only on the freshly computed sample so that ear
  // changes on the same edge as sample and sample_valid.
  always_comb begin
    state_next = state;
    if (win_last) begin
      case (state)
        EAR_LOW: begin
          if ({1'b0, scaled} >= (9'd128 + {1'b0, HYST})) begin
            state_next = EAR_HIGH;
          end
        end
        EAR_HIGH: begin
          if (scaled < (8'd128 - HYST)) begin
            state_next = EAR_LOW;
          end
        end
      endcase
    end
  end

  assign bus.fb_out       = fb;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = valid_r;
  assign bus.ear          = (state == EAR_HIGH);
  assign bus.ear_state    = state;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// tb_sigma_delta_adc
//   Self-checking bench for sigma_delta_adc with DECIM_LOG2=8, HYST=16.
//   A reference model counts comparator bits (two-clock synchronizer delay)
//   over enabled-clock windows and pushes {ear, sample} into exp_q; a monitor
//   pops and compares on every sample_valid and checks fb_out every cycle.
module tb_sigma_delta_adc;
  localparam int N    = 8;
  localparam int WIN  = 1 << N;
  localparam int HYST = 16;

  logic clk;
  logic reset;

  sigma_delta_adc_if bus ();

  sigma_delta_adc #(
    .DECIM_LOG2(N),
    .HYST      (8'(HYST))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  task automatic check(input string name, input int act, input int req);
    total_checks++;
    if (act != req) begin
      bad_checks++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];   // {ear, sample}
  int         pipe[$];    // comparator values still in flight to the bit stream
  int         ones_m;
  int         cnt_m;
  int         ear_m;
  logic       fb_exp = 1'b0;

  function automatic int scale_ref(input int cnt);
    int sat;
    sat = (cnt > WIN - 1) ? WIN - 1 : cnt;
    return (sat * 256) / WIN;
  endfunction

  always @(posedge clk) begin
    int b;
    int s;
    if (reset) begin
      pipe   = '{0, 0};
      ones_m = 0;
      cnt_m  = 0;
      ear_m  = 0;
      fb_exp = 1'b0;
      exp_q.delete();
    end else begin
      b = pipe.pop_front();
      pipe.push_back(int'(bus.comp_in));
      fb_exp = b[0];
      if (bus.enable) begin
        ones_m += b;
        cnt_m++;
        if (cnt_m == WIN) begin
          s = scale_ref(ones_m);
          if (ear_m == 0 && s >= 128 + HYST) ear_m = 1;
          else if (ear_m == 1 && s < 128 - HYST) ear_m = 0;
          exp_q.push_back({ear_m[0], s[7:0]});
          ones_m = 0;
          cnt_m  = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    check("fb_out", int'(bus.fb_out), int'(fb_exp));
    if (bus.sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_sample", int'(bus.sample), int'(e[7:0]));
        check("sb_ear", int'(bus.ear), int'(e[8]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode: 0 const 0, 1 const 1, 2 toggle, 3 ones at [10,10+k), 4 random k% density
  task automatic run(input int n, input int mode, input int k,
                     input int off_lo, input int off_hi,
                     output int nv, output int last_i);
    nv     = 0;
    last_i = -1;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       bus.comp_in = 1'b0;
        1:       bus.comp_in = 1'b1;
        2:       bus.comp_in = ~i[0];
        3:       bus.comp_in = (i >= 10 && i < 10 + k);
        default: bus.comp_in = ($urandom_range(0, 99) < k);
      endcase
      if (mode == 4) bus.enable = ($urandom_range(0, 9) != 0);
      else           bus.enable = !(i >= off_lo && i < off_hi);
      @(negedge clk);
      if (bus.sample_valid === 1'b1) begin
        nv++;
        last_i = i;
      end
    end
  endtask

  task automatic do_reset(input int n, input logic comp);
    bus.comp_in = comp;
    bus.enable  = 1'b1;
    reset       = 1'b1;
    repeat (n) @(negedge clk);
    check("rst_sample", int'(bus.sample), 8'h80);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_ear", int'(bus.ear), 0);
    check("rst_fb", int'(bus.fb_out), 0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    int li;
    int hk[4]   = '{140, 150, 120, 100};
    int hear[4] = '{0, 1, 1, 0};

    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.comp_in = 1'b0;

    // reset with comp_in high, then constant ones
    do_reset(3, 1'b1);
    run(WIN, 1, 0, 0, 0, nv, li);
    check("first_valid_count", nv, 1);
    check("first_valid_latency", li + 1, 256);
    run(WIN, 1, 0, 0, 0, nv, li);
    check("ones_valid_at", li + 1, 256);
    check("ones_sample", int'(bus.sample), 8'hFF);
    check("ones_ear", int'(bus.ear), 1);

    // constant zeros after HIGH
    run(2 * WIN, 0, 0, 0, 0, nv, li);
    check("zeros_count", nv, 2);
    check("zeros_sample", int'(bus.sample), 8'h00);
    check("zeros_ear", int'(bus.ear), 0);

    // toggling input -> midscale, ear stays low
    do_reset(2, 1'b0);
    run(2 * WIN, 2, 0, 0, 0, nv, li);
    check("toggle_count", nv, 2);
    check("toggle_sample", int'(bus.sample), 8'h80);
    check("toggle_ear", int'(bus.ear), 0);

    // hysteresis windows
    do_reset(2, 1'b0);
    for (int w = 0; w < 4; w++) begin
      run(WIN, 3, hk[w], 0, 0, nv, li);
      check("hyst_valid_at", li + 1, 256);
      check("hyst_sample", int'(bus.sample), hk[w]);
      check("hyst_ear", int'(bus.ear), hear[w]);
    end

    // enable gap stretches the window
    do_reset(2, 1'b0);
    run(WIN, 1, 0, 0, 0, nv, li);
    run(WIN + 50, 1, 0, 100, 150, nv, li);
    check("gap_count", nv, 1);
    check("gap_interval", li + 1, 306);
    check("gap_sample", int'(bus.sample), 8'hFF);

    // reset mid-window discards the partial window
    run(100, 1, 0, 0, 0, nv, li);
    check("pre_reset_none", nv, 0);
    do_reset(2, 1'b1);
    run(200, 1, 0, 0, 0, nv, li);
    check("post_reset_none", nv, 0);

    // randomized windows against the model
    do_reset(2, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run(300, 4, $urandom_range(0, 100), 0, 0, nv, li);
    end
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
